// File: rtl/bp_be_pkg.sv
// Shared types and defaults for the back-end system-pipe interrupt sequencer.
// Optional drain watchdog in the sequencer is enabled with BP_BE_IRQ_WATCHDOG_EN.
package bp_be_pkg;

  typedef enum logic [0:0] {
    e_bp_default_cfg = 1'b0
  } bp_params_e;

  typedef enum logic [1:0] {
    e_idle   = 2'd0,
    e_drain  = 2'd1,
    e_fire   = 2'd2,
    e_settle = 2'd3
  } bp_be_irq_seq_state_e;

  localparam int unsigned bp_be_irq_settle_cycles_lp = 32'd2;
  localparam int unsigned bp_be_irq_timeout_lp       = 32'd1024;

endpackage

// File: rtl/bp_be_irq_drain_tracker.sv
// In-flight shadow of dispatched instructions plus the "pipeline drained" qualifier
// used by the interrupt sequencer before it takes an interrupt.
module bp_be_irq_drain_tracker
 #(parameter int unsigned pipe_depth_p = 32'd3)
  (input  logic clk_i,
   input  logic reset_i,
   input  logic clear_i,
   input  logic accept_i,
   input  logic commit_v_i,
   input  logic pipe_mem_ready_i,
   input  logic pipe_long_ready_i,
   output logic drained_o);

  logic [pipe_depth_p-1:0] shadow_r;
  logic [pipe_depth_p-1:0] shadow_n;

  // Shift in accepted issues each cycle; a flush drops everything in flight.
  always_comb begin
    shadow_n = shadow_r;
    if (clear_i) begin
      shadow_n = '0;
    end else begin
      shadow_n = (shadow_r << 1'b1) | pipe_depth_p'(accept_i);
    end
  end

  // Shadow register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      shadow_r <= '0;
    end else begin
      shadow_r <= shadow_n;
    end
  end

  assign drained_o = (shadow_r == '0) & pipe_mem_ready_i & pipe_long_ready_i & ~commit_v_i;

endmodule

// File: rtl/bp_be_sys_irq_sequencer.sv
// Interrupt-entry sequencer: closes dispatch, drains in-flight work, fires a one-cycle take
// strobe and holds dispatch closed while the trap commits. Watchdog: BP_BE_IRQ_WATCHDOG_EN.
module bp_be_sys_irq_sequencer
  import bp_be_pkg::*;
 #(parameter bp_params_e  bp_params_p     = e_bp_default_cfg,
   parameter int unsigned pipe_depth_p    = 32'd3,
   parameter int unsigned settle_cycles_p = bp_be_irq_settle_cycles_lp,
   parameter int unsigned timeout_p       = bp_be_irq_timeout_lp)
  (input  logic clk_i,
   input  logic reset_i,
   input  logic irq_pending_i,
   input  logic issue_v_i,
   input  logic commit_v_i,
   input  logic flush_i,
   input  logic pipe_mem_ready_i,
   input  logic pipe_long_ready_i,
   output logic issue_ready_o,
   output logic interrupt_v_o,
   output logic drain_flush_o,
   output logic watchdog_o);

  localparam int unsigned settle_width_lp = $clog2(settle_cycles_p + 32'd1);
  localparam logic [settle_width_lp-1:0] settle_load_lp = settle_width_lp'(settle_cycles_p - 32'd1);

  if ((pipe_depth_p < 32'd1) || (settle_cycles_p < 32'd1) || (timeout_p < 32'd1)
      || (bp_params_p != e_bp_default_cfg)) begin : g_bad_cfg
    $error("bp_be_sys_irq_sequencer: unsupported parameterisation");
  end

  bp_be_irq_seq_state_e state_r, state_n;
  logic [settle_width_lp-1:0] settle_cnt_r, settle_cnt_n;
  logic drained_s;
  logic accept_s;
  logic shadow_clear_s;

  assign issue_ready_o  = (state_r == e_idle) & ~irq_pending_i & ~reset_i;
  assign interrupt_v_o  = (state_r == e_fire);
  assign accept_s       = issue_v_i & issue_ready_o;
  assign shadow_clear_s = flush_i | drain_flush_o;

  bp_be_irq_drain_tracker
   #(.pipe_depth_p(pipe_depth_p))
   tracker
    (.clk_i            (clk_i),
     .reset_i          (reset_i),
     .clear_i          (shadow_clear_s),
     .accept_i         (accept_s),
     .commit_v_i       (commit_v_i),
     .pipe_mem_ready_i (pipe_mem_ready_i),
     .pipe_long_ready_i(pipe_long_ready_i),
     .drained_o        (drained_s));

  // Next-state logic; settle ignores the pending line so the trap can commit undisturbed.
  always_comb begin
    state_n      = state_r;
    settle_cnt_n = settle_cnt_r;
    case (state_r)
      e_idle: begin
        if (irq_pending_i) begin
          state_n = e_drain;
        end else begin
          state_n = e_idle;
        end
      end
      e_drain: begin
        if (~irq_pending_i) begin
          state_n = e_idle;
        end else if (drained_s) begin
          state_n = e_fire;
        end else begin
          state_n = e_drain;
        end
      end
      e_fire: begin
        state_n      = e_settle;
        settle_cnt_n = settle_load_lp;
      end
      e_settle: begin
        if (settle_cnt_r == '0) begin
          state_n = e_idle;
        end else begin
          settle_cnt_n = settle_cnt_r - 1'b1;
        end
      end
      default: begin
        state_n      = e_idle;
        settle_cnt_n = '0;
      end
    endcase
  end

  // State and settle counter registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r      <= e_idle;
      settle_cnt_r <= '0;
    end else begin
      state_r      <= state_n;
      settle_cnt_r <= settle_cnt_n;
    end
  end

`ifdef BP_BE_IRQ_WATCHDOG_EN
  localparam int unsigned timeout_width_lp = $clog2(timeout_p + 32'd1);
  localparam logic [timeout_width_lp-1:0] timeout_last_lp = timeout_width_lp'(timeout_p - 32'd1);

  logic [timeout_width_lp-1:0] wd_cnt_r;
  logic drain_flush_r;
  logic watchdog_r;
  logic stay_drain_s;

  assign stay_drain_s = (state_r == e_drain) & (state_n == e_drain);

  // Drain watchdog: the flush pulse lands on the cycle the count reaches timeout_p.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wd_cnt_r      <= '0;
      drain_flush_r <= 1'b0;
      watchdog_r    <= 1'b0;
    end else if (stay_drain_s && (wd_cnt_r == timeout_last_lp)) begin
      wd_cnt_r      <= '0;
      drain_flush_r <= 1'b1;
      watchdog_r    <= 1'b1;
    end else if (stay_drain_s) begin
      wd_cnt_r      <= wd_cnt_r + 1'b1;
      drain_flush_r <= 1'b0;
    end else begin
      wd_cnt_r      <= '0;
      drain_flush_r <= 1'b0;
    end
  end

  assign drain_flush_o = drain_flush_r;
  assign watchdog_o    = watchdog_r;
`else
  assign drain_flush_o = 1'b0;
  assign watchdog_o    = 1'b0;
`endif

endmodule

// File: tb/tb_bp_be_sys_irq_sequencer.sv
// Self-checking bench for bp_be_sys_irq_sequencer: directed vector table, watchdog
// sequence and randomized traffic against a cycle-count based reference model.
module tb_bp_be_sys_irq_sequencer;

  localparam int D = 3;
  localparam int S = 2;
  localparam int T = 16;
`ifdef BP_BE_IRQ_WATCHDOG_EN
  localparam bit wd_en = 1'b1;
`else
  localparam bit wd_en = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic reset_i, irq_pending_i, issue_v_i, commit_v_i, flush_i;
  logic pipe_mem_ready_i, pipe_long_ready_i;
  logic issue_ready_o, interrupt_v_o, drain_flush_o, watchdog_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  bp_be_sys_irq_sequencer
   #(.pipe_depth_p(D), .settle_cycles_p(S), .timeout_p(T))
   dut
    (.clk_i            (clk_i),
     .reset_i          (reset_i),
     .irq_pending_i    (irq_pending_i),
     .issue_v_i        (issue_v_i),
     .commit_v_i       (commit_v_i),
     .flush_i          (flush_i),
     .pipe_mem_ready_i (pipe_mem_ready_i),
     .pipe_long_ready_i(pipe_long_ready_i),
     .issue_ready_o    (issue_ready_o),
     .interrupt_v_o    (interrupt_v_o),
     .drain_flush_o    (drain_flush_o),
     .watchdog_o       (watchdog_o));

  typedef struct {
    logic rst, pend, iss, com, fl, mem, lng;
    logic exp_rdy, exp_irq;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, pend, iss, com, fl, mem, lng, exp_rdy, exp_irq);
    vec_t v;
    v.rst = rst; v.pend = pend; v.iss = iss; v.com = com; v.fl = fl;
    v.mem = mem; v.lng = lng; v.exp_rdy = exp_rdy; v.exp_irq = exp_irq;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, p, i, c, f, m, l);
    reset_i = r; irq_pending_i = p; issue_v_i = i; commit_v_i = c;
    flush_i = f; pipe_mem_ready_i = m; pipe_long_ready_i = l;
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b expected=%0b", name, act, exp);
    end
  endtask

  // Reference model state: expressed as cycle numbers rather than an FSM encoding.
  bit waiting, flush_next, wd;
  int fire_at, last_accept, last_clear, age;

  task automatic model_reset(input int t);
    waiting = 1'b0; flush_next = 1'b0; wd = 1'b0; age = 0;
    fire_at = -100; last_clear = t;
  endtask

  initial begin
    logic pend_q;
    drive(1, 0, 0, 0, 0, 1, 1);
    repeat (2) @(posedge clk_i);
    #1;

    // reset state
    add(0,0,0,0,0,1,1, 1,0);
    // already drained; pending and issue together: pending wins
    add(0,1,1,0,0,1,1, 0,0);
    add(0,1,0,0,0,1,1, 0,0);
    add(0,0,0,0,0,1,1, 0,1);
    add(0,0,0,0,0,1,1, 0,0);
    add(0,0,0,0,0,1,1, 0,0);
    add(0,0,0,0,0,1,1, 1,0);
    // issue then pending: wait for shadow and commit
    add(0,0,1,0,0,1,1, 1,0);
    add(0,1,0,0,0,1,1, 0,0);
    add(0,1,0,0,0,1,1, 0,0);
    add(0,1,0,0,0,1,1, 0,0);
    add(0,1,0,1,0,1,1, 0,0);
    add(0,1,0,0,0,1,1, 0,0);
    add(0,0,0,0,0,1,1, 0,1);
    add(0,0,0,0,0,1,1, 0,0);
    add(0,0,0,0,0,1,1, 0,0);
    add(0,0,0,0,0,1,1, 1,0);
    // pending abandoned during drain
    add(0,1,0,0,0,1,0, 0,0);
    add(0,1,0,0,0,1,0, 0,0);
    add(0,1,0,0,0,1,0, 0,0);
    add(0,0,0,0,0,1,0, 0,0);
    add(0,0,0,0,0,1,1, 1,0);
    // three in flight, flush during drain
    add(0,0,1,0,0,1,1, 1,0);
    add(0,0,1,0,0,1,1, 1,0);
    add(0,0,1,0,0,1,1, 1,0);
    add(0,1,0,0,0,1,1, 0,0);
    add(0,1,0,0,1,1,1, 0,0);
    add(0,1,0,0,0,1,1, 0,0);
    add(0,0,0,0,0,1,1, 0,1);
    add(0,0,0,0,0,1,1, 0,0);
    add(0,0,0,0,0,1,1, 0,0);
    add(0,0,0,0,0,1,1, 1,0);
    // reset during settle
    add(0,1,0,0,0,1,1, 0,0);
    add(0,1,0,0,0,1,1, 0,0);
    add(0,0,0,0,0,1,1, 0,1);
    add(1,0,0,0,0,1,1, 0,0);
    add(1,0,0,0,0,1,1, 0,0);
    add(0,0,0,0,0,1,1, 1,0);

    for (int n = 0; n < vecs.size(); n++) begin
      drive(vecs[n].rst, vecs[n].pend, vecs[n].iss, vecs[n].com, vecs[n].fl, vecs[n].mem, vecs[n].lng);
      #3;
      check($sformatf("vec%0d_issue_ready", n), issue_ready_o, vecs[n].exp_rdy);
      check($sformatf("vec%0d_interrupt_v", n), interrupt_v_o, vecs[n].exp_irq);
      check($sformatf("vec%0d_drain_flush", n), drain_flush_o, 1'b0);
      check($sformatf("vec%0d_watchdog", n), watchdog_o, 1'b0);
      @(posedge clk_i);
      #1;
    end

    // Long pipe stuck: watchdog fires on drain cycle 16 when built in
    for (int i = 0; i < 22; i++) begin
      drive(0, 1, 0, 0, 0, 1, 0);
      #3;
      check($sformatf("wd%0d_drain_flush", i), drain_flush_o, wd_en && (i - 1 == T));
      check($sformatf("wd%0d_watchdog", i), watchdog_o, wd_en && (i - 1 >= T));
      check($sformatf("wd%0d_interrupt_v", i), interrupt_v_o, 1'b0);
      check($sformatf("wd%0d_issue_ready", i), issue_ready_o, 1'b0);
      @(posedge clk_i);
      #1;
    end
    drive(1, 0, 0, 0, 0, 1, 1);
    repeat (2) @(posedge clk_i);
    #1;

    // Randomized traffic against the reference model
    model_reset(-1);
    last_accept = -1000;
    pend_q = 1'b0;
    for (int t = 0; t < 4000; t++) begin
      logic r, i, c, f, m, l;
      bit busy, exp_rdy, exp_irq, exp_fl, shadow_busy, drained, fnext;
      if ($urandom_range(7) == 0) pend_q = ~pend_q;
      r = ($urandom_range(99) == 0);
      i = $urandom_range(1);
      c = ($urandom_range(3) == 0);
      f = ($urandom_range(15) == 0);
      m = ($urandom_range(7) != 0);
      l = ($urandom_range(15) != 0) && !(t % 500 > 450);
      drive(r, pend_q, i, c, f, m, l);

      busy        = (t >= fire_at) && (t <= fire_at + S);
      exp_irq     = (t == fire_at);
      exp_rdy     = !busy && !waiting && !pend_q && !r;
      exp_fl      = flush_next;
      shadow_busy = (last_accept >= t - D) && (last_accept > last_clear);
      drained     = !shadow_busy && m && l && !c;

      #3;
      check($sformatf("rnd%0d_issue_ready", t), issue_ready_o, exp_rdy);
      check($sformatf("rnd%0d_interrupt_v", t), interrupt_v_o, exp_irq);
      check($sformatf("rnd%0d_drain_flush", t), drain_flush_o, exp_fl);
      check($sformatf("rnd%0d_watchdog", t), watchdog_o, wd);

      if (i && exp_rdy) last_accept = t;
      if (f || exp_fl) last_clear = t;
      if (r) begin
        model_reset(t);
      end else begin
        fnext = 1'b0;
        if (busy) begin
          waiting = 1'b0;
        end else if (waiting) begin
          if (!pend_q) begin
            waiting = 1'b0; age = 0;
          end else if (drained) begin
            waiting = 1'b0; age = 0; fire_at = t + 1;
          end else if (wd_en) begin
            if (age == T - 1) begin
              fnext = 1'b1; wd = 1'b1; age = 0;
            end else begin
              age++;
            end
          end
        end else if (pend_q) begin
          waiting = 1'b1; age = 0;
        end
        flush_next = fnext;
      end
      @(posedge clk_i);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
